// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall controller for the 5-stage MIPS pipeline.
// Produces hold/bubble controls for IF/ID, ID/EX and EX/MEM from load-use
// detection, a multi-cycle mul/div latency sequencer and data-SRAM waits.
// Optional feature macro: STALL_PERF_CNT_EN enables the three stall
// performance counters; without it the perf ports read 32'd0 and no counter
// flops exist.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_wr_en,
    input  logic [4:0]  ex_wr_reg,
    input  logic        ex_is_load,
    input  logic        ex_md_start,
    input  logic        ex_md_is_div,
    input  logic        mem_req,
    input  logic        mem_data_ok,
    output logic        if_stall,
    output logic        id_stall,
    output logic        ex_stall,
    output logic        mem_stall,
    output logic        md_busy,
    output logic [31:0] perf_lu,
    output logic [31:0] perf_md,
    output logic [31:0] perf_mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // N can be as large as 2^CNT_W, so it needs one extra bit.
    localparam logic [CNT_W:0] MUL_N = (CNT_W + 1)'(MUL_CYCLES);
    localparam logic [CNT_W:0] DIV_N = (CNT_W + 1)'(DIV_CYCLES);

    md_state_t        state_r;
    md_state_t        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic [CNT_W:0]   n_s;
    logic             n_gt1_s;
    logic             mem_wait_s;
    logic             md_hold_s;
    logic             ex_stall_s;
    logic             load_use_s;
    logic             id_stall_s;
    logic             md_busy_s;

    // Hazard decode: all terms are combinational from inputs and current state.
    always_comb begin
        n_s        = ex_md_is_div ? DIV_N : MUL_N;
        n_gt1_s    = (n_s > (CNT_W + 1)'(1));
        mem_wait_s = mem_req & ~mem_data_ok;
        md_hold_s  = ((state_r == ST_IDLE) & ex_md_start & n_gt1_s) |
                     ((state_r == ST_BUSY) & (cnt_r != {CNT_W{1'b0}}));
        ex_stall_s = mem_wait_s | md_hold_s;
        load_use_s = ex_is_load & ex_wr_en & (ex_wr_reg != 5'd0) &
                     ((id_uses_rs & (id_rs == ex_wr_reg)) |
                      (id_uses_rt & (id_rt == ex_wr_reg)));
        // A held ID/EX must not also take a bubble.
        id_stall_s = load_use_s & ~ex_stall_s;
        md_busy_s  = (state_r != ST_IDLE) | md_hold_s;
    end

    // Latency-sequencer next state; N is only looked at when leaving IDLE.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (ex_md_start & n_gt1_s) begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = CNT_W'(n_s - (CNT_W + 1)'(2));
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end else if (ex_stall_s) begin
                    // Op is finished but the pipe is held by memory: park in DONE
                    // so the still-asserted ex_md_start cannot retrigger.
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!ex_stall_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Sequencer state and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Stall outputs, forced low while reset is asserted.
    always_comb begin
        if (rst) begin
            if_stall  = 1'b0;
            id_stall  = 1'b0;
            ex_stall  = 1'b0;
            mem_stall = 1'b0;
            md_busy   = 1'b0;
        end else begin
            if_stall  = ex_stall_s | load_use_s;
            id_stall  = id_stall_s;
            ex_stall  = ex_stall_s;
            mem_stall = mem_wait_s;
            md_busy   = md_busy_s;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_lu_r;
    logic [31:0] perf_md_r;
    logic [31:0] perf_mem_r;

    // Free-running stall-cycle counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_r  <= 32'd0;
            perf_md_r  <= 32'd0;
            perf_mem_r <= 32'd0;
        end else begin
            perf_lu_r  <= perf_lu_r  + {31'd0, id_stall_s};
            perf_md_r  <= perf_md_r  + {31'd0, md_hold_s};
            perf_mem_r <= perf_mem_r + {31'd0, mem_wait_s};
        end
    end

    // Counter outputs read zero while reset is asserted, like every other output.
    always_comb begin
        if (rst) begin
            perf_lu  = 32'd0;
            perf_md  = 32'd0;
            perf_mem = 32'd0;
        end else begin
            perf_lu  = perf_lu_r;
            perf_md  = perf_md_r;
            perf_mem = perf_mem_r;
        end
    end
`else
    assign perf_lu  = 32'd0;
    assign perf_md  = 32'd0;
    assign perf_mem = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. The driver sets inputs just after each
// rising edge and queues the hand-computed expected outputs for that cycle;
// a monitor on the falling edge pops and compares.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_wr_reg;
    logic        id_uses_rs, id_uses_rt, ex_wr_en, ex_is_load;
    logic        ex_md_start, ex_md_is_div, mem_req, mem_data_ok;
    logic        if_stall, id_stall, ex_stall, mem_stall, md_busy;
    logic [31:0] perf_lu, perf_md, perf_mem;

`ifdef STALL_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic [4:0]  st;      // {if, id, ex, mem, md_busy}
        bit          chk_perf;
        logic [31:0] lu;
        logic [31:0] md;
        logic [31:0] mem;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_is_load(ex_is_load),
        .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
        .mem_req(mem_req), .mem_data_ok(mem_data_ok),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
        .mem_stall(mem_stall), .md_busy(md_busy),
        .perf_lu(perf_lu), .perf_md(perf_md), .perf_mem(perf_mem)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0] got;
            e   = exp_q.pop_front();
            got = {if_stall, id_stall, ex_stall, mem_stall, md_busy};
            checks++;
            if (got !== e.st) begin
                failures++;
                $display("FAIL %s: {if,id,ex,mem,busy} got=%b exp=%b at %0t",
                         e.nm, got, e.st, $time);
            end
            if (e.chk_perf) begin
                checks++;
                if (perf_lu !== e.lu || perf_md !== e.md || perf_mem !== e.mem) begin
                    failures++;
                    $display("FAIL %s_perf: got lu=%0d md=%0d mem=%0d exp lu=%0d md=%0d mem=%0d",
                             e.nm, perf_lu, perf_md, perf_mem, e.lu, e.md, e.mem);
                end
            end
        end
    end

    task automatic clr_in();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_wr_en = 1'b0; ex_wr_reg = 5'd0; ex_is_load = 1'b0;
        ex_md_start = 1'b0; ex_md_is_div = 1'b0;
        mem_req = 1'b0; mem_data_ok = 1'b0;
    endtask

    // Queue expectation for the current cycle, then advance one clock.
    task automatic cyc(input string nm, input logic [4:0] st);
        exp_t e;
        e.nm = nm; e.st = st; e.chk_perf = 1'b0;
        e.lu = 32'd0; e.md = 32'd0; e.mem = 32'd0;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic cyc_perf(input string nm, input logic [4:0] st,
                            input int lu, input int md, input int mem);
        exp_t e;
        e.nm = nm; e.st = st; e.chk_perf = 1'b1;
        e.lu  = PERF_ON ? 32'(lu)  : 32'd0;
        e.md  = PERF_ON ? 32'(md)  : 32'd0;
        e.mem = PERF_ON ? 32'(mem) : 32'd0;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        rst = 1'b1;
        @(posedge clk); #1;
        cyc_perf("reset0", 5'b00000, 0, 0, 0);
        cyc_perf("reset1", 5'b00000, 0, 0, 0);
        rst = 1'b0;
        cyc("idle", 5'b00000);

        // Load-use on rs
        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_wr_reg = 5'd5;
        id_rs = 5'd5; id_uses_rs = 1'b1;
        cyc("lu_rs", 5'b11000);
        ex_wr_reg = 5'd0; id_rs = 5'd0;
        cyc("lu_r0", 5'b00000);
        clr_in();

        // Divide: 32 hold cycles, then a final non-stalled BUSY cycle
        ex_md_start = 1'b1; ex_md_is_div = 1'b1;
        for (int k = 0; k < 32; k++) cyc("div_hold", 5'b10101);
        cyc("div_last", 5'b00001);
        clr_in();
        cyc("div_idle", 5'b00000);

        // Memory wait: 3 waiting cycles, then ack
        mem_req = 1'b1;
        for (int k = 0; k < 3; k++) cyc("mem_wait", 5'b10110);
        mem_data_ok = 1'b1;
        cyc("mem_ack", 5'b00000);
        clr_in();
        cyc_perf("perf_a", 5'b00000, 1, 32, 3);

        // Multiply: single hold cycle
        ex_md_start = 1'b1;
        cyc("mul_hold", 5'b10101);
        cyc("mul_last", 5'b00001);
        clr_in();
        cyc("mul_idle", 5'b00000);

        // Divide overlapped with a memory wait that outlasts it by 4 cycles
        ex_md_start = 1'b1; ex_md_is_div = 1'b1; mem_req = 1'b1;
        for (int k = 0; k < 32; k++) cyc("ovl_hold", 5'b10111);
        cyc("ovl_last", 5'b10111);
        for (int k = 0; k < 4; k++) cyc("ovl_done", 5'b10111);
        mem_req = 1'b0;
        cyc("ovl_release", 5'b00001);
        clr_in();
        cyc("ovl_idle", 5'b00000);

        // Reset mid-divide with cnt=10
        ex_md_start = 1'b1; ex_md_is_div = 1'b1;
        for (int k = 0; k < 22; k++) cyc("rst_pre", 5'b10101);
        rst = 1'b1;
        cyc_perf("rst_mid", 5'b00000, 0, 0, 0);
        rst = 1'b0;
        clr_in();
        cyc_perf("rst_after", 5'b00000, 0, 0, 0);
        cyc("rst_after2", 5'b00000);

        // Load-use on rt, qualifiers, and overlap with memory wait
        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_wr_reg = 5'd7;
        id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd7; id_uses_rs = 1'b0;
        cyc("lu_rt", 5'b11000);
        id_uses_rt = 1'b0;
        cyc("lu_nouse", 5'b00000);
        id_uses_rt = 1'b1; ex_wr_en = 1'b0;
        cyc("lu_nowr", 5'b00000);
        ex_wr_en = 1'b1; ex_is_load = 1'b0;
        cyc("lu_notload", 5'b00000);
        ex_is_load = 1'b1; mem_req = 1'b1;
        cyc("lu_memwait", 5'b10110);
        clr_in();
        cyc_perf("perf_b", 5'b00000, 1, 0, 1);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
